// File: rtl/simon_core_arbiter.sv
// simon_core_arbiter: round-robin sharing of one iterative SIMON core
// between two block-cipher clients. One block in flight at a time; the
// core's sticky doneData is absorbed by a CLEAR state, and a watchdog
// turns a hung core into an error response instead of a deadlock.
module simon_core_arbiter #(
    parameter int N  = 16,
    parameter int T  = 32,
    parameter int WD = T + 8,
    parameter int Wb = 6
) (
    input  logic                clk,
    input  logic                R,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_enc_dec,
    input  logic [1:0][2*N-1:0] req_data,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [2*N-1:0]      rsp_data,
    output logic                rsp_err,
    output logic                core_newData,
    output logic                core_readData,
    output logic                core_enc_dec,
    output logic [2*N-1:0]      core_plain,
    input  logic                core_doneData,
    input  logic                core_doneKey,
    input  logic [2*N-1:0]      core_cipher
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_CLEAR, S_BUSY, S_RETURN
    } state_t;

    localparam logic [Wb-1:0] WD_LIM = Wb'(WD);

    state_t         r_state;
    logic           r_sel;
    logic           r_last;
    logic           r_enc;
    logic           r_newData;
    logic           r_err;
    logic [1:0]     r_rsp_valid;
    logic [2*N-1:0] r_plain;
    logic [2*N-1:0] r_rsp_data;
    logic [Wb-1:0]  r_wd;

    logic           w_grant;
    logic           w_gnt;
    logic           w_wd_hit;
    logic [Wb-1:0]  w_wd_next;

    // Grant decode: single requester wins outright, a tie goes to the one not served last.
    always_comb begin
        w_gnt     = (req_valid == 2'b11) ? ~r_last : req_valid[1];
        w_grant   = (r_state == S_IDLE) && core_doneKey && (|req_valid) && !R;
        req_ready = 2'b00;
        if (w_grant) req_ready[w_gnt] = 1'b1;
    end

    // Saturating watchdog increment and its abort threshold.
    always_comb begin
        w_wd_next = (r_wd == {Wb{1'b1}}) ? r_wd : r_wd + Wb'(1);
        w_wd_hit  = (w_wd_next == WD_LIM);
    end

    // readData is the same-cycle acknowledge of doneData, so it cannot be registered.
    assign core_readData = (r_state == S_BUSY) && core_doneData && !R;
    assign core_newData  = r_newData;
    assign core_enc_dec  = r_enc;
    assign core_plain    = r_plain;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_err       = r_err;

    // Arbiter FSM with registered outputs; captured block stays on core_plain until the next grant.
    always_ff @(posedge clk) begin
        if (R) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_last      <= 1'b1;
            r_enc       <= 1'b0;
            r_newData   <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_plain     <= '0;
            r_rsp_data  <= '0;
            r_wd        <= '0;
        end else begin
            r_newData <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_plain   <= req_data[w_gnt];
                        r_enc     <= req_enc_dec[w_gnt];
                        r_sel     <= w_gnt;
                        r_last    <= w_gnt;
                        r_newData <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= S_CLEAR;
                end
                S_CLEAR, S_BUSY: begin
                    r_wd <= w_wd_next;
                    if (r_state == S_BUSY && core_doneData) begin
                        // a real completion beats a watchdog expiring in the same cycle
                        r_rsp_data  <= core_cipher;
                        r_err       <= 1'b0;
                        r_rsp_valid <= {r_sel, ~r_sel};
                        r_state     <= S_RETURN;
                    end else if (w_wd_hit) begin
                        r_rsp_data  <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= {r_sel, ~r_sel};
                        r_state     <= S_RETURN;
                    end else if (r_state == S_CLEAR && !core_doneData) begin
                        r_state <= S_BUSY;
                    end
                end
                S_RETURN: begin
                    if (rsp_ready[r_sel]) begin
                        r_rsp_valid <= 2'b00;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simon_core_arbiter.sv
// tb_simon_core_arbiter: random two-client traffic against a behavioural
// stub of the SIMON core, checked every cycle by a transaction-level model
// of the arbiter (grant rule, fixed latencies, expected cipher results).
module tb_simon_core_arbiter;
    localparam int N  = 16;
    localparam int T  = 32;
    localparam int WD = T + 8;
    localparam int Wb = 6;
    localparam int BW = 2 * N;

    logic                clk = 1'b0;
    logic                R;
    logic [1:0]          req_valid, req_enc_dec, req_ready;
    logic [1:0][BW-1:0]  req_data;
    logic [1:0]          rsp_valid, rsp_ready;
    logic [BW-1:0]       rsp_data, core_plain, core_cipher;
    logic                rsp_err, core_newData, core_readData, core_enc_dec;
    logic                core_doneData, core_doneKey;

    always #5 clk = ~clk;

    simon_core_arbiter #(.N(N), .T(T), .WD(WD), .Wb(Wb)) dut (
        .clk(clk), .R(R),
        .req_valid(req_valid), .req_enc_dec(req_enc_dec), .req_data(req_data),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_newData(core_newData), .core_readData(core_readData),
        .core_enc_dec(core_enc_dec), .core_plain(core_plain),
        .core_doneData(core_doneData), .core_doneKey(core_doneKey), .core_cipher(core_cipher)
    );

    // ---------------- SIMON32/64 reference, fixed key 1918_1110_0908_0100
    function automatic logic [15:0] rol(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] ff(input logic [15:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    function automatic logic [31:0] simon(input logic [31:0] blk, input bit enc);
        logic [15:0] k [32];
        logic [15:0] x, y, tmp;
        logic [61:0] z;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        k[0] = 16'h0100; k[1] = 16'h0908; k[2] = 16'h1110; k[3] = 16'h1918;
        for (int i = 4; i < 32; i++) begin
            tmp  = rol(k[i-1], 13) ^ k[i-3];
            tmp  = tmp ^ rol(tmp, 15);
            k[i] = ~k[i-4] ^ tmp ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
        end
        x = blk[31:16];
        y = blk[15:0];
        if (enc) begin
            for (int i = 0; i < 32; i++) begin
                tmp = x; x = y ^ ff(x) ^ k[i]; y = tmp;
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                tmp = y; y = x ^ ff(y) ^ k[i]; x = tmp;
            end
        end
        return {x, y};
    endfunction

    // ---------------- core stub: s1, T rounds, s3, then sticky done
    bit          kd, hang;
    int          cst, ccnt;
    logic [31:0] cin;
    bit          cenc;
    assign core_doneKey = kd;

    // Stale done is dropped one cycle after newData so CLEAR really has to wait.
    always @(posedge clk) begin
        if (R) begin
            cst <= 0; ccnt <= 0; core_doneData <= 1'b0; core_cipher <= '0;
        end else if (core_newData) begin
            cst <= 1; cin <= core_plain; cenc <= core_enc_dec;
        end else begin
            case (cst)
                1: begin cst <= 2; ccnt <= 0; core_doneData <= 1'b0; end
                2: if (ccnt == T - 1) cst <= 3; else ccnt <= ccnt + 1;
                3: if (hang) cst <= 4;
                   else begin core_doneData <= 1'b1; core_cipher <= simon(cin, cenc); cst <= 0; end
                default: ;
            endcase
        end
    end

    // ---------------- bookkeeping
    typedef struct { logic [31:0] d; bit e; } blk_t;
    blk_t        q0[$], q1[$];
    logic [31:0] cur_d [2];
    bit          cur_e [2];
    bit          asrt  [2];
    int          vprob, rprob, rdelay;
    bit          rnd_kd, post_rst;

    // transaction model
    bit          free, last, out_v, out_s, out_hung;
    int          out_acc, vcnt, cyc, lat;
    logic [31:0] out_exp;

    // DUT-observed history
    int          dq[$], aq[$];
    logic [31:0] last_rsp [2];
    bit          last_err [2];
    int          cnt_nd, cnt_rd, cnt_rr;

    int n_chk, n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pending();
        return q0.size() + q1.size() + int'(asrt[0]) + int'(asrt[1]) + int'(out_v);
    endfunction

    task automatic push(input int r, input logic [31:0] d, input bit e);
        blk_t b;
        b.d = d; b.e = e;
        if (r == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    // One clock: check at negedge against the model, then drive after posedge.
    task automatic tick();
        logic [1:0] er, ev;
        int g;
        blk_t b;
        @(negedge clk);
        if (R) begin
            free = 1; last = 1; out_v = 0; vcnt = 0;
        end else begin
            if (post_rst) begin
                chk("rst_ctl", 64'({rsp_valid, rsp_err, core_newData, core_readData, core_enc_dec}), 64'd0);
                chk("rst_data", 64'(rsp_data), 64'd0);
                chk("rst_plain", 64'(core_plain), 64'd0);
                post_rst = 0;
            end
            if (req_ready != 2'b00) begin dq.push_back(int'(req_ready[1])); aq.push_back(cyc); end
            if (req_ready[0]) cnt_rr++;
            if (core_newData) cnt_nd++;
            if (core_readData) cnt_rd++;

            er = 2'b00; g = -1;
            if (free && kd && req_valid != 2'b00) begin
                if (req_valid == 2'b11) g = last ? 0 : 1;
                else g = req_valid[1] ? 1 : 0;
                er[g] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("newData", 64'(core_newData), 64'(out_v && cyc == out_acc + 1));
            chk("readData", 64'(core_readData), 64'(out_v && !out_hung && cyc == out_acc + T + 4));
            ev = 2'b00;
            if (out_v && cyc >= out_acc + (out_hung ? WD + 2 : T + 5)) ev[out_s] = 1'b1;
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            if (out_v && rsp_valid != 2'b00 && lat < 0) lat = cyc - out_acc;
            if (ev != 2'b00) begin
                chk("rsp_data", 64'(rsp_data), 64'(out_hung ? 32'd0 : out_exp));
                chk("rsp_err", 64'(rsp_err), 64'(out_hung));
                vcnt++;
                if (rsp_ready[out_s]) begin
                    last_rsp[out_s] = rsp_data; last_err[out_s] = rsp_err;
                    out_v = 0; free = 1; vcnt = 0;
                end
            end
            if (g >= 0) begin
                free = 0; last = g[0]; out_v = 1; out_s = g[0]; out_acc = cyc;
                out_hung = hang; out_exp = simon(cur_d[g], cur_e[g]);
                asrt[g] = 0; lat = -1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!asrt[0] && q0.size() > 0 && ($urandom % 100) < vprob) begin
            b = q0.pop_front(); cur_d[0] = b.d; cur_e[0] = b.e; asrt[0] = 1;
        end
        if (!asrt[1] && q1.size() > 0 && ($urandom % 100) < vprob) begin
            b = q1.pop_front(); cur_d[1] = b.d; cur_e[1] = b.e; asrt[1] = 1;
        end
        for (int i = 0; i < 2; i++) begin
            req_valid[i]   = asrt[i];
            req_data[i]    = asrt[i] ? cur_d[i] : $urandom;
            req_enc_dec[i] = asrt[i] ? cur_e[i] : 1'($urandom % 2);
            rsp_ready[i]   = 1'($urandom % 2);
            if (out_v && int'(out_s) == i)
                rsp_ready[i] = (vcnt >= rdelay) && (($urandom % 100) < rprob);
        end
        if (rnd_kd) kd = ($urandom % 8) != 0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() > 0 && n < budget) begin tick(); n++; end
        chk("drain", 64'(pending()), 64'd0);
    endtask

    task automatic do_reset();
        R = 1'b1; tick(); R = 1'b0; post_rst = 1;
    endtask

    initial begin
        int n;
        R = 1'b1; kd = 1; hang = 0; rnd_kd = 0; post_rst = 0;
        req_valid = '0; req_enc_dec = '0; req_data = '0; rsp_ready = '0;
        vprob = 100; rprob = 100; rdelay = 0; cyc = 0; lat = -1;
        free = 1; last = 1; out_v = 0; vcnt = 0;
        asrt[0] = 0; asrt[1] = 0;
        n_chk = 0; n_fail = 0;

        tick(); tick(); R = 1'b0; post_rst = 1; tick();

        // key not ready: both waiting, no grant until doneKey rises, then requester 0
        kd = 0; cnt_nd = 0; dq.delete();
        push(0, $urandom, 1); push(1, $urandom, 0);
        repeat (21) tick();
        chk("kd_nogrant", 64'(dq.size()), 64'd0);
        chk("kd_no_newdata", 64'(cnt_nd), 64'd0);
        kd = 1; tick();
        chk("kd_first_grant", 64'(dq.size() > 0 ? dq[0] : 9), 64'd0);
        drain(300);

        // known-answer encrypt on requester 0
        cnt_rr = 0;
        push(0, 32'h6565_6877, 1);
        drain(100);
        chk("kat_enc", 64'(last_rsp[0]), 64'h0000_0000_c69b_e9bb);
        chk("kat_enc_lat", 64'(lat), 64'd37);
        chk("kat_enc_rdy", 64'(cnt_rr), 64'd1);

        // known-answer decrypt on requester 1
        cnt_nd = 0; cnt_rd = 0;
        push(1, 32'hc69b_e9bb, 0);
        drain(100);
        chk("kat_dec", 64'(last_rsp[1]), 64'h0000_0000_6565_6877);
        chk("kat_dec_nd", 64'(cnt_nd), 64'd1);
        chk("kat_dec_rd", 64'(cnt_rd), 64'd1);

        // contention, back-to-back
        dq.delete(); aq.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, $urandom, 1'($urandom % 2));
            push(1, $urandom, 1'($urandom % 2));
        end
        drain(600);
        chk("cont_cnt", 64'(dq.size()), 64'd8);
        for (int i = 0; i < dq.size(); i++) chk("cont_order", 64'(dq[i]), 64'(i % 2));
        for (int i = 1; i < aq.size(); i++) chk("cont_gap", 64'(aq[i] - aq[i-1]), 64'(T + 6));

        // contention with rsp_ready held off 10 cycles
        rdelay = 10; dq.delete(); aq.delete();
        for (int i = 0; i < 2; i++) begin
            push(0, $urandom, 1'($urandom % 2));
            push(1, $urandom, 1'($urandom % 2));
        end
        drain(600);
        for (int i = 0; i < dq.size(); i++) chk("dly_order", 64'(dq[i]), 64'(i % 2));
        for (int i = 1; i < aq.size(); i++) chk("dly_gap", 64'(aq[i] - aq[i-1]), 64'(T + 16));
        rdelay = 0;

        // hung core, then normal recovery
        hang = 1;
        push(0, $urandom, 1);
        drain(200);
        chk("hung_err", 64'(last_err[0]), 64'd1);
        chk("hung_data", 64'(last_rsp[0]), 64'd0);
        chk("hung_lat", 64'(lat), 64'(WD + 2));
        hang = 0;
        push(1, 32'hc69b_e9bb, 0);
        drain(200);
        chk("hung_recover", 64'({last_err[1], last_rsp[1]}), 64'h0000_0000_6565_6877);

        // reset 10 cycles after ISSUE, then a fresh request
        push(0, 32'h6565_6877, 1);
        n = 0;
        while (!(out_v && cyc == out_acc + 11) && n < 60) begin tick(); n++; end
        chk("rst_reach", 64'(out_v), 64'd1);
        do_reset();
        tick();
        push(1, 32'h6565_6877, 1);
        drain(200);
        chk("rst_fresh", 64'(last_rsp[1]), 64'h0000_0000_c69b_e9bb);

        // random traffic with flickering doneKey
        rnd_kd = 1; vprob = 60; rprob = 50; rdelay = 2;
        for (int i = 0; i < 60; i++) push(int'($urandom % 2), $urandom, 1'($urandom % 2));
        drain(8000);
        rnd_kd = 0; kd = 1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
